// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD 7-segment display path.
// Segment patterns are active-low; the bit order is {dp,g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/bcd_sseg_decoder.sv
// Combinational BCD-to-7-segment decoder with decimal point.
// Codes outside 0-9 render as a minus sign.
module bcd_sseg_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] sseg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_MINUS;
    case (code_i)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_MINUS;
    endcase
  end

  always_comb begin
    sseg_o              = SEG_OFF;
    sseg_o[SEG_DP]      = ~dp_i;
    sseg_o[SEG_G:SEG_A] = glyph;
  end

endmodule

// File: rtl/bcd_disp_mux.sv
// Captures four BCD digits on load and scans them onto a 4-digit common-anode
// display with optional leading-zero blanking and per-digit decimal points.
module bcd_disp_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned N = 18
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       load_amisha,
  input  logic [3:0] bcd3_amisha,
  input  logic [3:0] bcd2_amisha,
  input  logic [3:0] bcd1_amisha,
  input  logic [3:0] bcd0_amisha,
  input  logic [3:0] dp_in_amisha,
  input  logic       blank_en_amisha,
  output logic [3:0] an_amisha,
  output logic [7:0] sseg_amisha
);

  logic [N-1:0]      cnt_q, cnt_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic [3:0]        dp_q, dp_d;
  logic              loaded_q, loaded_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        sseg_q, sseg_d;

  logic [1:0]        sel;
  logic [3:0]        lead_zero;
  logic [7:0]        dec_sseg;

  assign sel = cnt_q[N-1 -: 2];

  bcd_sseg_decoder u_dec (
    .code_i (dig_q[sel]),
    .dp_i   (dp_q[sel]),
    .sseg_o (dec_sseg)
  );

  always_comb begin
    cnt_d    = cnt_q + N'(1);
    dig_d    = dig_q;
    dp_d     = dp_q;
    loaded_d = loaded_q;
    if (load_amisha) begin
      dig_d    = {bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha};
      dp_d     = dp_in_amisha;
      loaded_d = 1'b1;
    end
  end

  // A digit is a leading zero when it and all higher digits are 0; digit0 never is.
  always_comb begin
    lead_zero    = '0;
    lead_zero[3] = (dig_q[3] == 4'd0);
    lead_zero[2] = lead_zero[3] & (dig_q[2] == 4'd0);
    lead_zero[1] = lead_zero[2] & (dig_q[1] == 4'd0);
  end

  // Outputs use the pre-edge captured data, so a coincident load shows up one cycle later.
  always_comb begin
    an_d   = AN_OFF;
    sseg_d = SEG_OFF;
    if (loaded_q && !(blank_en_amisha && lead_zero[sel])) begin
      an_d   = ~(4'b0001 << sel);
      sseg_d = dec_sseg;
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      dp_q     <= '0;
      loaded_q <= 1'b0;
      an_q     <= AN_OFF;
      sseg_q   <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      dp_q     <= dp_d;
      loaded_q <= loaded_d;
      an_q     <= an_d;
      sseg_q   <= sseg_d;
    end
  end

  assign an_amisha   = an_q;
  assign sseg_amisha = sseg_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Directed plus randomized bench for bcd_disp_mux (N=4, 4 clocks per digit).
module tb_bcd_disp_mux;

  localparam int N = 4;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic       load_amisha;
  logic [3:0] bcd3_amisha, bcd2_amisha, bcd1_amisha, bcd0_amisha;
  logic [3:0] dp_in_amisha;
  logic       blank_en_amisha;
  logic [3:0] an_amisha;
  logic [7:0] sseg_amisha;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int         m_cnt;
  int         m_dig[4];
  bit         m_dp[4];
  bit         m_loaded;

  bcd_disp_mux #(.N(N)) dut (
    .clk_amisha      (clk_amisha),
    .reset_amisha    (reset_amisha),
    .load_amisha     (load_amisha),
    .bcd3_amisha     (bcd3_amisha),
    .bcd2_amisha     (bcd2_amisha),
    .bcd1_amisha     (bcd1_amisha),
    .bcd0_amisha     (bcd0_amisha),
    .dp_in_amisha    (dp_in_amisha),
    .blank_en_amisha (blank_en_amisha),
    .an_amisha       (an_amisha),
    .sseg_amisha     (sseg_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  function automatic logic [6:0] glyph(int code);
    case (code)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void model_out(output logic [3:0] an_e, output logic [7:0] sseg_e);
    int  k = m_cnt / 4;
    bit  blanked = 0;
    an_e   = 4'b1111;
    sseg_e = 8'hFF;
    if (blank_en_amisha && k > 0) begin
      blanked = 1;
      for (int j = k; j < 4; j++) if (m_dig[j] != 0) blanked = 0;
    end
    if (m_loaded && !blanked) begin
      an_e      = 4'b1111;
      an_e[k]   = 1'b0;
      sseg_e    = {~m_dp[k], glyph(m_dig[k])};
    end
  endfunction

  task automatic check(string tag, logic [3:0] an_e, logic [7:0] sseg_e);
    n_checks++;
    assert (an_amisha === an_e && sseg_amisha === sseg_e) n_pass++;
    else $error("FAIL %s: got an=%b sseg=%h, expected an=%b sseg=%h",
                tag, an_amisha, sseg_amisha, an_e, sseg_e);
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_loaded = 0;
    for (int j = 0; j < 4; j++) begin
      m_dig[j] = 0;
      m_dp[j]  = 0;
    end
  endtask

  // One clock: predict registered outputs from pre-edge state, advance model, compare.
  task automatic step(string tag);
    logic [3:0] a;
    logic [7:0] s;
    model_out(a, s);
    m_cnt = (m_cnt + 1) % (1 << N);
    if (load_amisha) begin
      m_dig[3] = bcd3_amisha; m_dig[2] = bcd2_amisha;
      m_dig[1] = bcd1_amisha; m_dig[0] = bcd0_amisha;
      for (int j = 0; j < 4; j++) m_dp[j] = dp_in_amisha[j];
      m_loaded = 1;
    end
    @(posedge clk_amisha);
    #1;
    check(tag, a, s);
  endtask

  task automatic do_load(int d3, int d2, int d1, int d0, logic [3:0] dp);
    bcd3_amisha  = 4'(d3);
    bcd2_amisha  = 4'(d2);
    bcd1_amisha  = 4'(d1);
    bcd0_amisha  = 4'(d0);
    dp_in_amisha = dp;
    load_amisha  = 1'b1;
    step("load");
    load_amisha  = 1'b0;
  endtask

  task automatic run(string tag, int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    reset_amisha    = 1'b0;
    load_amisha     = 1'b0;
    bcd3_amisha     = '0;
    bcd2_amisha     = '0;
    bcd1_amisha     = '0;
    bcd0_amisha     = '0;
    dp_in_amisha    = '0;
    blank_en_amisha = 1'b0;
    model_reset();

    // Held in reset: dark
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_amisha);
      #1;
      check("reset_hold", 4'b1111, 8'hFF);
    end
    reset_amisha = 1'b1;
    run("no_load", 40);

    // 4321, no blanking
    do_load(4, 3, 2, 1, 4'b0000);
    run("frame_4321", 32);

    // 0050 with and without blanking
    blank_en_amisha = 1'b1;
    do_load(0, 0, 5, 0, 4'b0000);
    run("blank_0050", 32);
    blank_en_amisha = 1'b0;
    run("noblank_0050", 16);

    // All zero with dp on digit0
    blank_en_amisha = 1'b1;
    do_load(0, 0, 0, 0, 4'b0001);
    run("zero_dp0", 16);

    // Invalid code counts as nonzero
    do_load(0, 11, 0, 7, 4'b0100);
    run("minus_0B07", 32);

    // Asynchronous reset mid-digit2
    for (int i = 0; i < 32 && m_cnt != 9; i++) step("to_digit2");
    check_mid_reset: begin
      reset_amisha = 1'b0;
      #1;
      check("async_reset", 4'b1111, 8'hFF);
      model_reset();
      @(posedge clk_amisha);
      #1;
      check("reset_pulse", 4'b1111, 8'hFF);
      reset_amisha = 1'b1;
    end
    run("dark_after_reset", 20);
    do_load(1, 2, 3, 4, 4'b1010);
    run("reload", 32);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) blank_en_amisha = ~blank_en_amisha;
      if ($urandom_range(0, 9) == 0) begin
        do_load(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                4'($urandom_range(0, 15)));
      end else begin
        step("random");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
